video_mem_arbiter: RTL and testbench

- Shares the single command port of the video object RAM (144-bit object words) between three requesters: the matrix unit (MAT, read/write), the clipping unit (CLIP, read) and the loadback path (LDB, read).
- Arbitration is round-robin, at most one memory operation per cycle.
- Read data is returned with a per-requester valid strobe.
- LDB reads are unpacked into coordinate and attribute registers.

---
 rtl/video_mem_pkg.sv | 35 +++
 rtl/video_mem_arbiter_rr_arb3.sv | 46 ++++
 rtl/video_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_video_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_mem_pkg.sv
// Shared types and constants for the video object RAM arbiter.
// Requester IDs double as bit positions in the request/grant vectors.
package video_mem_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 9;
    localparam int DW_DEF    = 144;

    typedef enum logic [1:0] {
        REQ_MAT  = 2'd0,
        REQ_CLIP = 2'd1,
        REQ_LDB  = 2'd2
    } req_id_e;

    // Loadback word layout: four (x, y) pairs followed by the attribute half-word.
    localparam int FIELD_W  = 16;
    localparam int X0_LSB   = 0;
    localparam int Y0_LSB   = 16;
    localparam int X1_LSB   = 32;
    localparam int Y1_LSB   = 48;
    localparam int X2_LSB   = 64;
    localparam int Y2_LSB   = 80;
    localparam int X3_LSB   = 96;
    localparam int Y3_LSB   = 112;
    localparam int ATTR_LSB = 128;

    function automatic req_id_e rr_next(input req_id_e id);
        case (id)
            REQ_MAT:  return REQ_CLIP;
            REQ_CLIP: return REQ_LDB;
            default:  return REQ_MAT;
        endcase
    endfunction

endpackage

// File: rtl/video_mem_arbiter_rr_arb3.sv
// Three-way round-robin arbiter; the pointer holds the last granted requester.
// Grant is combinational, the pointer advances at the edge ending the grant cycle.
module rr_arb3
    import video_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       gnt_any,
    output req_id_e    gnt_id
);

    req_id_e last;
    req_id_e c1;
    req_id_e c2;

    // Resetting to LDB makes the first search order MAT > CLIP > LDB.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_LDB;
        end else if (gnt_any) begin
            last <= gnt_id;
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = REQ_MAT;
        c1      = rr_next(last);
        c2      = rr_next(c1);
        if (req[c1]) begin
            gnt_any = 1'b1;
            gnt_id  = c1;
        end else if (req[c2]) begin
            gnt_any = 1'b1;
            gnt_id  = c2;
        end else if (req[last]) begin
            gnt_any = 1'b1;
            gnt_id  = last;
        end
    end

    assign gnt = gnt_any ? (3'b001 << gnt_id) : 3'b000;

endmodule

// File: rtl/video_mem_arbiter.sv
// Shares the video object RAM command port between MAT, CLIP and LDB.
// Command stage at N+1, read return with per-requester strobe at N+2.
module video_mem_arbiter
    import video_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mat_req,
    input  logic          mat_we,
    input  logic [AW-1:0] mat_addr,
    input  logic [DW-1:0] mat_wdata,
    output logic          mat_gnt,
    output logic          mat_rvalid,
    input  logic          clip_req,
    input  logic [AW-1:0] clip_addr,
    output logic          clip_gnt,
    output logic          clip_rvalid,
    input  logic          ldb_req,
    input  logic [AW-1:0] ldb_addr,
    output logic          ldb_gnt,
    output logic          ldb_rvalid,
    output logic [DW-1:0] rdata,
    output logic [15:0]   ldb_x0,
    output logic [15:0]   ldb_y0,
    output logic [15:0]   ldb_x1,
    output logic [15:0]   ldb_y1,
    output logic [15:0]   ldb_x2,
    output logic [15:0]   ldb_y2,
    output logic [15:0]   ldb_x3,
    output logic [15:0]   ldb_y3,
    output logic [15:0]   ldb_attr,
    output logic          addr_err,
    output logic [AW-1:0] vm_addr,
    output logic          vm_rd_en,
    output logic          vm_wr_en,
    output logic [DW-1:0] vm_wdata,
    input  logic [DW-1:0] vm_rdata
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [2:0]    gnt;
    logic          gnt_any;
    req_id_e       gnt_id;
    logic [AW-1:0] gnt_addr;
    logic          in_range;
    logic          is_write;

    logic          t1_valid;
    req_id_e       t1_id;
    logic          t1_err;
    logic          rv_valid;
    req_id_e       rv_id;
    logic [DW-1:0] ret_word;

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({ldb_req, clip_req, mat_req}),
        .gnt     (gnt),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    assign mat_gnt  = gnt[REQ_MAT];
    assign clip_gnt = gnt[REQ_CLIP];
    assign ldb_gnt  = gnt[REQ_LDB];

    always_comb begin
        gnt_addr = mat_addr;
        case (gnt_id)
            REQ_CLIP: gnt_addr = clip_addr;
            REQ_LDB:  gnt_addr = ldb_addr;
            default:  gnt_addr = mat_addr;
        endcase
    end

    assign in_range = gnt_addr < DEPTH_A;
    assign is_write = gnt_any && (gnt_id == REQ_MAT) && mat_we;
    // Out-of-range reads still travel the tag pipeline so the requester sees a zero return.
    assign ret_word = t1_err ? '0 : vm_rdata;

    assign mat_rvalid  = rv_valid && (rv_id == REQ_MAT);
    assign clip_rvalid = rv_valid && (rv_id == REQ_CLIP);
    assign ldb_rvalid  = rv_valid && (rv_id == REQ_LDB);

    always_ff @(posedge clk) begin
        if (rst) begin
            vm_addr  <= '0;
            vm_rd_en <= 1'b0;
            vm_wr_en <= 1'b0;
            vm_wdata <= '0;
            addr_err <= 1'b0;
            t1_valid <= 1'b0;
            t1_id    <= REQ_MAT;
            t1_err   <= 1'b0;
            rv_valid <= 1'b0;
            rv_id    <= REQ_MAT;
            rdata    <= '0;
            ldb_x0   <= '0;
            ldb_y0   <= '0;
            ldb_x1   <= '0;
            ldb_y1   <= '0;
            ldb_x2   <= '0;
            ldb_y2   <= '0;
            ldb_x3   <= '0;
            ldb_y3   <= '0;
            ldb_attr <= '0;
        end else begin
            vm_rd_en <= gnt_any && in_range && !is_write;
            vm_wr_en <= is_write && in_range;
            addr_err <= gnt_any && !in_range;
            if (gnt_any) begin
                vm_addr  <= gnt_addr;
                vm_wdata <= mat_wdata;
            end
            t1_valid <= gnt_any && !is_write;
            t1_id    <= gnt_id;
            t1_err   <= !in_range;
            rv_valid <= t1_valid;
            rv_id    <= t1_id;
            if (t1_valid) begin
                rdata <= ret_word;
            end
            if (t1_valid && (t1_id == REQ_LDB)) begin
                ldb_x0   <= ret_word[X0_LSB   +: FIELD_W];
                ldb_y0   <= ret_word[Y0_LSB   +: FIELD_W];
                ldb_x1   <= ret_word[X1_LSB   +: FIELD_W];
                ldb_y1   <= ret_word[Y1_LSB   +: FIELD_W];
                ldb_x2   <= ret_word[X2_LSB   +: FIELD_W];
                ldb_y2   <= ret_word[Y2_LSB   +: FIELD_W];
                ldb_x3   <= ret_word[X3_LSB   +: FIELD_W];
                ldb_y3   <= ret_word[Y3_LSB   +: FIELD_W];
                ldb_attr <= ret_word[ATTR_LSB +: FIELD_W];
            end
        end
    end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with a behavioural object RAM
// (write at the clock edge, read data follows the registered address).
module tb_video_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 144;

    logic          clk = 1'b0;
    logic          rst;
    logic          mat_req, mat_we, clip_req, ldb_req;
    logic [AW-1:0] mat_addr, clip_addr, ldb_addr;
    logic [DW-1:0] mat_wdata;
    logic          mat_gnt, clip_gnt, ldb_gnt;
    logic          mat_rvalid, clip_rvalid, ldb_rvalid;
    logic [DW-1:0] rdata;
    logic [15:0]   ldb_x0, ldb_y0, ldb_x1, ldb_y1, ldb_x2, ldb_y2, ldb_x3, ldb_y3, ldb_attr;
    logic          addr_err;
    logic [AW-1:0] vm_addr;
    logic          vm_rd_en, vm_wr_en;
    logic [DW-1:0] vm_wdata, vm_rdata;

    logic [DW-1:0] mem [0:511];
    logic [2:0]    gv, rv;
    logic [DW-1:0] ldb_word;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .mat_req(mat_req), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .mat_gnt(mat_gnt), .mat_rvalid(mat_rvalid),
        .clip_req(clip_req), .clip_addr(clip_addr), .clip_gnt(clip_gnt), .clip_rvalid(clip_rvalid),
        .ldb_req(ldb_req), .ldb_addr(ldb_addr), .ldb_gnt(ldb_gnt), .ldb_rvalid(ldb_rvalid),
        .rdata(rdata),
        .ldb_x0(ldb_x0), .ldb_y0(ldb_y0), .ldb_x1(ldb_x1), .ldb_y1(ldb_y1),
        .ldb_x2(ldb_x2), .ldb_y2(ldb_y2), .ldb_x3(ldb_x3), .ldb_y3(ldb_y3),
        .ldb_attr(ldb_attr), .addr_err(addr_err),
        .vm_addr(vm_addr), .vm_rd_en(vm_rd_en), .vm_wr_en(vm_wr_en),
        .vm_wdata(vm_wdata), .vm_rdata(vm_rdata)
    );

    always @(posedge clk) begin
        if (vm_wr_en) mem[vm_addr] <= vm_wdata;
    end
    assign vm_rdata = mem[vm_addr];

    assign gv = {ldb_gnt, clip_gnt, mat_gnt};
    assign rv = {ldb_rvalid, clip_rvalid, mat_rvalid};

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wpat(input int i);
        return {9{16'(i)}};
    endfunction

    function automatic logic [2:0] oh(input int id);
        logic [2:0] b;
        b = 3'b001;
        return b << id;
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mat_req = 1'b1; mat_we = 1'b1; mat_addr = a; mat_wdata = d;
        step;
        mat_req = 1'b0; mat_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mat_req = 1'b0; mat_we = 1'b0; mat_addr = '0; mat_wdata = '0;
        clip_req = 1'b0; clip_addr = '0; ldb_req = 1'b0; ldb_addr = '0;
        for (int j = 0; j < 9; j++) ldb_word[16*j +: 16] = 16'h0011 * 16'(j + 1);

        step; step;
        chk("rst_vm_addr", vm_addr, 0);
        chk("rst_vm_rd_en", vm_rd_en, 0);
        chk("rst_vm_wr_en", vm_wr_en, 0);
        chk("rst_vm_wdata", vm_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rv, 0);
        chk("rst_gnt", gv, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_ldb_x0", ldb_x0, 0);
        chk("rst_ldb_attr", ldb_attr, 0);
        rst = 1'b0;

        for (int i = 1; i <= 4; i++) wr(AW'(i), wpat(i));
        wr(9'd7, ldb_word);

        // MAT write then read of addr 5
        mat_req = 1'b1; mat_we = 1'b1; mat_addr = 9'd5; mat_wdata = {18{8'hA5}};
        @(negedge clk);
        chk("t1_wr_gnt", mat_gnt, 1);
        step;
        mat_we = 1'b0;
        chk("t1_vm_wr_en", vm_wr_en, 1);
        chk("t1_vm_addr", vm_addr, 5);
        chk("t1_vm_wdata", vm_wdata, {18{8'hA5}});
        @(negedge clk);
        chk("t1_rd_gnt", mat_gnt, 1);
        step;
        mat_req = 1'b0;
        chk("t1_vm_rd_en", vm_rd_en, 1);
        chk("t1_no_wr_rvalid", mat_rvalid, 0);
        step;
        chk("t1_mat_rvalid", mat_rvalid, 1);
        chk("t1_rdata", rdata, {18{8'hA5}});

        // round robin with all three requesters held
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            mat_req = (k < 9); clip_req = (k < 9); ldb_req = (k < 9);
            mat_we = 1'b0; mat_addr = 9'd1; clip_addr = 9'd2; ldb_addr = 9'd3;
            @(negedge clk);
            chk($sformatf("rr_gnt_%0d", k), gv, (k < 9) ? oh(k % 3) : 3'b000);
            if (k >= 2) begin
                chk($sformatf("rr_rvalid_%0d", k), rv, oh((k - 2) % 3));
                chk($sformatf("rr_rdata_%0d", k), rdata, wpat((k - 2) % 3 + 1));
            end else begin
                chk($sformatf("rr_rvalid_%0d", k), rv, 0);
            end
            step;
        end
        chk("rr_rvalid_idle", rv, 0);
        chk("rr_ldb_x0", ldb_x0, 16'd3);
        chk("rr_ldb_attr", ldb_attr, 16'd3);

        // LDB unpack of addr 7
        ldb_req = 1'b1; ldb_addr = 9'd7;
        @(negedge clk);
        chk("ldb_gnt", ldb_gnt, 1);
        step;
        ldb_req = 1'b0;
        chk("ldb_rvalid_early", ldb_rvalid, 0);
        step;
        chk("ldb_rvalid", ldb_rvalid, 1);
        chk("ldb_x0", ldb_x0, 16'h0011);
        chk("ldb_y0", ldb_y0, 16'h0022);
        chk("ldb_x1", ldb_x1, 16'h0033);
        chk("ldb_y1", ldb_y1, 16'h0044);
        chk("ldb_x2", ldb_x2, 16'h0055);
        chk("ldb_y2", ldb_y2, 16'h0066);
        chk("ldb_x3", ldb_x3, 16'h0077);
        chk("ldb_y3", ldb_y3, 16'h0088);
        chk("ldb_attr", ldb_attr, 16'h0099);
        step;
        chk("ldb_rvalid_once", ldb_rvalid, 0);
        chk("ldb_attr_hold", ldb_attr, 16'h0099);

        // out-of-range write and read of addr 40
        mat_req = 1'b1; mat_we = 1'b1; mat_addr = 9'd40; mat_wdata = {18{8'h3C}};
        @(negedge clk);
        chk("oor_wr_gnt", mat_gnt, 1);
        step;
        mat_req = 1'b0; mat_we = 1'b0;
        clip_req = 1'b1; clip_addr = 9'd40;
        chk("oor_wr_vm_wr_en", vm_wr_en, 0);
        chk("oor_wr_vm_rd_en", vm_rd_en, 0);
        chk("oor_wr_addr_err", addr_err, 1);
        @(negedge clk);
        chk("oor_rd_gnt", clip_gnt, 1);
        step;
        clip_req = 1'b0;
        chk("oor_rd_vm_wr_en", vm_wr_en, 0);
        chk("oor_rd_vm_rd_en", vm_rd_en, 0);
        chk("oor_rd_addr_err", addr_err, 1);
        step;
        chk("oor_clip_rvalid", clip_rvalid, 1);
        chk("oor_rdata", rdata, 0);
        chk("oor_addr_err_end", addr_err, 0);

        // reset while a CLIP read is in flight
        clip_req = 1'b1; clip_addr = 9'd2;
        @(negedge clk);
        chk("flush_gnt", clip_gnt, 1);
        step;
        clip_req = 1'b0;
        rst = 1'b1;
        chk("flush_vm_rd_en", vm_rd_en, 1);
        step;
        rst = 1'b0;
        chk("flush_rvalid", rv, 0);
        chk("flush_rdata", rdata, 0);
        chk("flush_vm_addr", vm_addr, 0);
        chk("flush_vm_rd_en_rst", vm_rd_en, 0);
        chk("flush_vm_wdata", vm_wdata, 0);
        chk("flush_ldb_attr", ldb_attr, 0);
        chk("flush_ldb_y3", ldb_y3, 0);
        chk("flush_addr_err", addr_err, 0);
        step;
        chk("flush_rvalid_n1", rv, 0);
        step;
        chk("flush_rvalid_n2", rv, 0);

        // back-to-back CLIP reads of addrs 1..4
        for (int k = 0; k < 6; k++) begin
            clip_req = (k < 4);
            clip_addr = AW'(k + 1);
            @(negedge clk);
            chk($sformatf("burst_gnt_%0d", k), clip_gnt, (k < 4));
            chk($sformatf("burst_rvalid_%0d", k), clip_rvalid, (k >= 2));
            if (k >= 2) chk($sformatf("burst_rdata_%0d", k), rdata, wpat(k - 1));
            step;
        end
        chk("burst_rvalid_idle", clip_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
